dcache_sa_controller: RTL and testbench
=======================================

// Module: dcache_sa_controller
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache controller.
//  Sits between the EX/MEM pipeline register and the 256-bit data memory.
//  Replaces the direct-mapped controller. Adds configurable ways/sets, true-LRU replacement and saturating hit/miss counters.
//  cpu_stall_o freezes PC and all pipeline registers while a miss is serviced.
// PARAMETERS
//  WAYS       2    associativity; power of two, 1..8
//  SETS       16   sets per way; power of two >= 2
//  LINE_W     256  line width in bits; equals the memory data width
//  ADDR_W     32   byte address width
//  DATA_W     32   CPU word width
//  CNT_W      32   width of the performance counters
// PORTS
//  clk_i           in   1        clock
//  rst_i           in   1        asynchronous reset, active-high
//  cpu_addr_i      in   ADDR_W   byte address from EX/MEM ALU result
//  cpu_data_i      in   DATA_W   store data
//  cpu_MemRead_i   in   1        load request
//  cpu_MemWrite_i  in   1        store request
//  cpu_data_o      out  DATA_W   load data, valid when request && !cpu_stall_o
//  cpu_stall_o     out  1        miss in progress; freeze pipeline
//  mem_data_i      in   LINE_W   refill line from memory
//  mem_ack_i       in   1        one-cycle memory completion pulse
//  mem_data_o      out  LINE_W   write-back line
//  mem_addr_o      out  ADDR_W   line-aligned memory address
//  mem_enable_o    out  1        memory request; held until mem_ack_i
//  mem_write_o     out  1        1 = write-back, 0 = refill
//  hit_cnt_o       out  CNT_W    saturating count of first-attempt hits
//  miss_cnt_o      out  CNT_W    saturating count of misses
// BEHAVIOUR
//  Address split:
//   - offset = log2(LINE_W/8) bits; word select = offset[MSB:2].
//   - index = log2(SETS) bits; tag = the remaining upper bits.
//  Per way/set state in internal registers: valid, dirty, tag, line, age[log2(WAYS)].
//  Request = cpu_MemRead_i | cpu_MemWrite_i. If both are high, treat the request as a store.
//  Hit: a valid way's tag matches. Resolution is combinational in the same cycle; no stall.
//   - Load: cpu_data_o = selected word in the same cycle.
//   - Store: at the next edge, write the word into the line and set dirty=1.
//  Miss: cpu_stall_o is asserted combinationally in the same cycle as the request.
//  Victim choice: the lowest-index invalid way; otherwise the way with age == WAYS-1.
//  FSM states: IDLE, MISS, WB, REFILL, DONE.
//   - IDLE -> MISS on a request that misses.
//   - MISS: if the victim is dirty, go to WB; otherwise go to REFILL.
//   - WB: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,0}, mem_data_o=victim line.
//     Hold all outputs until mem_ack_i, then go to REFILL.
//   - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,0}.
//     On mem_ack_i, latch mem_data_i into the victim way (valid=1, dirty=0, new tag); go to DONE.
//   - DONE -> IDLE. The request replays and now hits; a store then sets dirty.
//  mem_enable_o is 0 in IDLE, MISS and DONE. cpu_stall_o=1 in MISS, WB, REFILL and DONE.
//  LRU update happens on every hit edge in IDLE:
//   - the accessed way's age becomes 0;
//   - ways whose age was below the old age increment by 1;
//   - ages stay a permutation of 0..WAYS-1.
//  Counters:
//   - miss_cnt_o increments on the IDLE->MISS edge.
//   - hit_cnt_o increments on a hit edge in IDLE, except the single replay right after DONE.
//   - Both saturate at all-ones.
//  mem_ack_i outside WB/REFILL is ignored. Address and data inputs are sampled only in IDLE; they are held by the frozen pipeline.
//  Reset (any time, including mid-miss), effective immediately:
//   - FSM=IDLE; every valid=0 and dirty=0; age of way w = w; counters = 0.
//   - mem_enable_o=0, mem_write_o=0, cpu_stall_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
//   - A memory transaction that was in flight is abandoned.
// TESTING
//  1. Cold load 0x100 with mem ack after 10 cycles:
//     stall 1 for MISS + REFILL(10) + DONE cycles; then load returns the refilled word.
//     miss_cnt=1, hit_cnt=0.
//  2. Store 0x104=0xDEADBEEF after T1, then load 0x104:
//     no stall, returns 0xDEADBEEF; hit_cnt=2, line dirty.
//  3. WAYS=2, SETS=16, line 32B: touch 0x100 (dirtied), 0x300, 0x500 (all set 8):
//     third access writes back mem_addr_o=0x100 with mem_write_o=1, then refills 0x500.
//     The 0x300 line survives (LRU check).
//  4. Back-to-back misses to the same set with delayed acks:
//     mem_enable_o held until mem_ack_i; stray ack in IDLE causes no state change.
//  5. rst_i pulsed during REFILL:
//     mem_enable_o and cpu_stall_o drop before the next edge; all lines invalid;
//     the next load of a formerly cached address misses.
//  6. Force 2^CNT_W-1 hits (CNT_W=4 build): hit_cnt_o holds at 4'hF.

Source files
------------

// File: rtl/dcache_sa_controller.sv
// N-way set-associative, write-back, write-allocate data cache controller with
// true-LRU replacement and saturating hit/miss counters.
module dcache_sa_controller #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MISS   = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];

    logic [WAY_W-1:0]  victim_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic              replay_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [WSEL_W-1:0] a_wsel;
    logic              req;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  lru_way;
    logic              any_inv;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] store_line;
    logic              idle_hit;
    logic              idle_miss;
    logic              unused_addr_bits;

    assign a_tag            = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign a_idx            = cpu_addr_i[OFF_W +: IDX_W];
    assign a_wsel           = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign idle_hit         = (state == S_IDLE) && req && hit;
    assign idle_miss        = (state == S_IDLE) && req && !hit;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[a_idx][w] && tag_q[a_idx][w] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[a_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[a_idx][w] == WAY_W'(WAYS - 1))
                lru_way = WAY_W'(w);
        end
        victim     = any_inv ? inv_way : lru_way;
        hit_line   = line_q[a_idx][hit_way];
        store_line = hit_line;
        store_line[a_wsel*DATA_W +: DATA_W] = cpu_data_i;
    end

    // Stall gating on rst_i keeps the pipeline free while reset is held with a request pending.
    assign cpu_stall_o  = !rst_i && ((state != S_IDLE) || idle_miss);
    assign cpu_data_o   = idle_hit ? hit_line[a_wsel*DATA_W +: DATA_W] : '0;
    assign mem_enable_o = (state == S_WB) || (state == S_REFILL);
    assign mem_write_o  = (state == S_WB);
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state)
            S_WB: begin
                mem_addr_o = {tag_q[req_idx_q][victim_q], req_idx_q, {OFF_W{1'b0}}};
                mem_data_o = line_q[req_idx_q][victim_q];
            end
            S_REFILL: mem_addr_o = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            victim_q   <= '0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            replay_q <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (idle_hit) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_q[a_idx][w] <= '0;
                            else if (age_q[a_idx][w] < age_q[a_idx][hit_way])
                                age_q[a_idx][w] <= age_q[a_idx][w] + WAY_W'(1);
                        end
                        if (cpu_MemWrite_i)
                            dirty_q[a_idx][hit_way] <= 1'b1;
                        // The replay after a refill was already counted as a miss.
                        if (!replay_q && hit_cnt_q != '1)
                            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end else if (idle_miss) begin
                        state     <= S_MISS;
                        victim_q  <= victim;
                        req_tag_q <= a_tag;
                        req_idx_q <= a_idx;
                        if (miss_cnt_q != '1)
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end
                end
                S_MISS:   state <= dirty_q[req_idx_q][victim_q] ? S_WB : S_REFILL;
                S_WB:     if (mem_ack_i) state <= S_REFILL;
                S_REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[req_idx_q][victim_q] <= 1'b1;
                        dirty_q[req_idx_q][victim_q] <= 1'b0;
                        state                        <= S_DONE;
                    end
                end
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // NOTE: line and tag storage carry no reset; valid_q alone decides whether their contents mean anything.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_REFILL && mem_ack_i) begin
            line_q[req_idx_q][victim_q] <= mem_data_i;
            tag_q[req_idx_q][victim_q]  <= req_tag_q;
        end else if (!rst_i && idle_hit && cpu_MemWrite_i) begin
            line_q[a_idx][hit_way] <= store_line;
        end
    end

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Scoreboard bench for dcache_sa_controller: a line-level reference model predicts
// load data, counters and memory traffic; monitors compare whenever the DUT responds.
module tb_dcache_sa_controller;

    localparam int WAYS    = 2;
    localparam int SETS    = 16;
    localparam int LINE_W  = 256;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LINE_B  = LINE_W / 8;
    localparam int WORDS   = LINE_W / DATA_W;

    typedef struct {
        bit              is_load;
        bit              miss;
        bit [DATA_W-1:0] data;
        int              hits;
        int              misses;
    } resp_t;

    typedef struct {
        bit              wr;
        bit [ADDR_W-1:0] addr;
        bit [LINE_W-1:0] data;
    } memtx_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [DATA_W-1:0] cpu_data_i = '0;
    logic              cpu_MemRead_i = 1'b0;
    logic              cpu_MemWrite_i = 1'b0;
    logic [DATA_W-1:0] cpu_data_o;
    logic              cpu_stall_o;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [CNT_W-1:0]  hit_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    dcache_sa_controller #(
        .WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: lines, MRU-ordered way lists, backing memory
    bit              m_valid [SETS][WAYS];
    bit              m_dirty [SETS][WAYS];
    bit [ADDR_W-1:0] m_base  [SETS][WAYS];
    bit [LINE_W-1:0] m_line  [SETS][WAYS];
    int              m_lru   [SETS][$];
    bit [LINE_W-1:0] memory  [bit [ADDR_W-1:0]];
    int              m_hits;
    int              m_misses;
    resp_t           resp_q[$];
    memtx_t          mem_q[$];

    function automatic bit [LINE_W-1:0] mem_line(input bit [ADDR_W-1:0] base);
        bit [LINE_W-1:0] l;
        if (!memory.exists(base)) begin
            for (int i = 0; i < WORDS; i++) l[i*DATA_W +: DATA_W] = $urandom;
            memory[base] = l;
        end
        return memory[base];
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_lru[s].push_back(w);
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input bit [ADDR_W-1:0] addr, input bit store,
                                input bit [DATA_W-1:0] data, output bit miss);
        bit [ADDR_W-1:0] base = addr - (addr % LINE_B);
        int set  = int'((addr / LINE_B) % SETS);
        int word = int'((addr % LINE_B) / 4);
        int way  = -1;
        resp_t r;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_base[set][w] == base) way = w;
        miss = (way < 0);
        if (miss) begin
            if (m_misses < CNT_MAX) m_misses++;
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[set][w]) way = w;
            if (way < 0) way = m_lru[set][m_lru[set].size() - 1];
            if (m_valid[set][way] && m_dirty[set][way]) begin
                mem_q.push_back('{1'b1, m_base[set][way], m_line[set][way]});
                memory[m_base[set][way]] = m_line[set][way];
            end
            mem_q.push_back('{1'b0, base, mem_line(base)});
            m_valid[set][way] = 1'b1;
            m_dirty[set][way] = 1'b0;
            m_base[set][way]  = base;
            m_line[set][way]  = memory[base];
        end
        r.is_load = !store;
        r.miss    = miss;
        r.hits    = m_hits;
        r.misses  = m_misses;
        if (store) begin
            m_line[set][way][word*DATA_W +: DATA_W] = data;
            m_dirty[set][way] = 1'b1;
        end
        r.data = m_line[set][way][word*DATA_W +: DATA_W];
        if (!miss && m_hits < CNT_MAX) m_hits++;
        for (int i = 0; i < m_lru[set].size(); i++)
            if (m_lru[set][i] == way) begin
                m_lru[set].delete(i);
                break;
            end
        m_lru[set].push_front(way);
        resp_q.push_back(r);
    endtask

    // ---------------- response monitor
    resp_t mon_r;
    always @(negedge clk_i) begin
        if (!rst_i && (cpu_MemRead_i || cpu_MemWrite_i) && !cpu_stall_o) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: DUT answered addr 0x%0h with nothing expected", cpu_addr_i);
            end else begin
                mon_r = resp_q.pop_front();
                if (mon_r.is_load)
                    check("load_data", LINE_W'(cpu_data_o), LINE_W'(mon_r.data));
                check("hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(mon_r.hits));
                check("miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(mon_r.misses));
            end
        end
    end

    // ---------------- memory responder / transaction monitor
    bit              in_txn = 1'b0;
    bit              hold_ack = 1'b0;
    int              force_delay = -1;
    int              delay;
    int              cnt;
    memtx_t          cur;
    bit [ADDR_W-1:0] last_wb_addr = '0;

    always @(negedge clk_i) begin
        mem_ack_i = 1'b0;
        if (rst_i) begin
            in_txn = 1'b0;
        end else begin
            if (in_txn) begin
                check("mem_enable_held", LINE_W'(mem_enable_o), LINE_W'(1));
                check("mem_write_held", LINE_W'(mem_write_o), LINE_W'(cur.wr));
                check("mem_addr_held", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
            end else if (mem_enable_o) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: request addr 0x%0h write %0d", mem_addr_o, mem_write_o);
                    cur = '{mem_write_o, mem_addr_o, '0};
                end else begin
                    cur = mem_q.pop_front();
                end
                check("mem_write", LINE_W'(mem_write_o), LINE_W'(cur.wr));
                check("mem_addr", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
                if (cur.wr) begin
                    check("wb_data", mem_data_o, cur.data);
                    last_wb_addr = mem_addr_o;
                end
                in_txn = 1'b1;
                cnt    = 0;
                delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 6));
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{$urandom}};
            end
            if (in_txn && !(hold_ack && !cur.wr)) begin
                if (cnt >= delay) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = cur.data;
                    in_txn     = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // ---------------- driver
    task automatic do_access(input bit [ADDR_W-1:0] addr, input bit rd, input bit wr,
                             input bit [DATA_W-1:0] data, output int stalls);
        bit miss;
        bit done = 1'b0;
        model_access(addr, wr, data, miss);
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        check("access_completes", LINE_W'(done), LINE_W'(1));
        check("stall_vs_model", LINE_W'(stalls != 0), LINE_W'(miss));
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  stalls;
        bit  miss;
        bit  found;
        bit [ADDR_W-1:0] a;
        int  kind;

        model_reset();
        cpu_addr_i    = 32'h100;
        cpu_MemRead_i = 1'b1;
        #3;
        check("rst_stall", LINE_W'(cpu_stall_o), LINE_W'(0));
        check("rst_mem_enable", LINE_W'(mem_enable_o), LINE_W'(0));
        check("rst_hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(0));
        check("rst_miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(0));
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Cold load with a refill lasting 10 cycles.
        force_delay = 9;
        do_access(32'h100, 1'b1, 1'b0, '0, stalls);
        check("t1_stall_cycles", LINE_W'(stalls), LINE_W'(1 + 1 + 10 + 1));
        check("t1_miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(1));
        check("t1_hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(0));
        force_delay = -1;

        // Store then load of the same word, both hitting.
        do_access(32'h104, 1'b0, 1'b1, 32'hDEADBEEF, stalls);
        do_access(32'h104, 1'b1, 1'b0, '0, stalls);
        check("t2_hit_cnt", LINE_W'(hit_cnt_o), LINE_W'(2));

        // Three lines into set 8: dirty 0x100 is the LRU victim of 0x500.
        do_access(32'h300, 1'b1, 1'b0, '0, stalls);
        do_access(32'h500, 1'b1, 1'b0, '0, stalls);
        check("t3_wb_addr", LINE_W'(last_wb_addr), LINE_W'(32'h100));
        do_access(32'h300, 1'b1, 1'b0, '0, stalls);
        check("t3_survivor_no_stall", LINE_W'(stalls), LINE_W'(0));

        // Reset in the middle of a refill.
        hold_ack = 1'b1;
        model_access(32'hB00, 1'b0, '0, miss);
        cpu_addr_i    = 32'hB00;
        cpu_MemRead_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reached_refill", LINE_W'(found), LINE_W'(1));
        #2 rst_i = 1'b1;
        #1;
        check("t5_mem_enable_drop", LINE_W'(mem_enable_o), LINE_W'(0));
        check("t5_stall_drop", LINE_W'(cpu_stall_o), LINE_W'(0));
        check("t5_mem_addr", LINE_W'(mem_addr_o), LINE_W'(0));
        check("t5_miss_cnt", LINE_W'(miss_cnt_o), LINE_W'(0));
        resp_q.delete();
        mem_q.delete();
        model_reset();
        @(posedge clk_i);
        #1;
        cpu_MemRead_i = 1'b0;
        hold_ack      = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        do_access(32'h300, 1'b1, 1'b0, '0, stalls);
        check("t5_reload_misses", LINE_W'(stalls != 0), LINE_W'(1));

        // Saturating hit counter.
        for (int i = 0; i < 20; i++)
            do_access(32'h300 + 32'(4 * (i % 8)), 1'b1, 1'b0, '0, stalls);
        check("t6_hit_sat", LINE_W'(hit_cnt_o), LINE_W'(CNT_MAX));

        // Back-to-back misses to one set with delayed acks.
        force_delay = 4;
        do_access(32'h700, 1'b0, 1'b1, 32'h1234_5678, stalls);
        do_access(32'h900, 1'b1, 1'b0, '0, stalls);
        do_access(32'hD00, 1'b0, 1'b1, 32'hCAFE_F00D, stalls);
        do_access(32'h700, 1'b1, 1'b0, '0, stalls);
        force_delay = -1;

        // Randomised traffic over two sets with four tags each.
        for (int n = 0; n < 400; n++) begin
            a    = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(7, 8)) << 5)
                 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 4));
            case (kind)
                0, 1: do_access(a, 1'b1, 1'b0, $urandom, stalls);
                2:    do_access(a, 1'b0, 1'b1, $urandom, stalls);
                3:    do_access(a, 1'b1, 1'b1, $urandom, stalls);
                default: begin
                    @(posedge clk_i);
                    #1;
                end
            endcase
        end

        repeat (10) @(posedge clk_i);
        check("resp_q_drained", LINE_W'(resp_q.size()), LINE_W'(0));
        check("mem_q_drained", LINE_W'(mem_q.size()), LINE_W'(0));
        check("mem_idle_at_end", LINE_W'(mem_enable_o), LINE_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
